// File: rtl/data_mem_if.sv
// MEM-stage data-memory bus: request from the pipeline, ready_n/read data/error back.
interface data_mem_if;
  logic        require_mem_access;
  logic        write;
  logic [1:0]  size;
  logic [31:0] data_mem_addr;
  logic [31:0] data_to_mem;
  logic        data_mem_access_ready_n;
  logic [31:0] data_from_mem;
  logic        access_err;

  modport master (
    output require_mem_access, write, size, data_mem_addr, data_to_mem,
    input  data_mem_access_ready_n, data_from_mem, access_err
  );

  modport slave (
    input  require_mem_access, write, size, data_mem_addr, data_to_mem,
    output data_mem_access_ready_n, data_from_mem, access_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory slave: accepts one request, waits WAIT_CYCLES, then completes with a ready_n low pulse.
// state | meaning
// IDLE  | waiting for require_mem_access; request sampled only here
// BUSY  | wait states counting down on the latched request
// DONE  | single completion cycle, ready_n=0, access_err flags a fault
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  mem_if
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          req_write;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;

  logic          eff_write;
  logic [1:0]    eff_size;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_data;
  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic          fault;
  logic          enter_done;
  logic          commit;

  logic [31:0]   mem [DEPTH_WORDS];

  // With zero wait states DONE is entered straight from IDLE, so the live request is committed.
  always_comb begin
    eff_write = req_write;
    eff_size  = req_size;
    eff_addr  = req_addr;
    eff_data  = req_data;
    if (state == IDLE) begin
      eff_write = mem_if.write;
      eff_size  = mem_if.size;
      eff_addr  = mem_if.data_mem_addr;
      eff_data  = mem_if.data_to_mem;
    end
  end

  always_comb begin
    be       = 4'b0000;
    fault    = 1'b0;
    word_off = eff_addr[31:2] - BASE_ADDR[31:2];
    idx      = word_off[AW-1:0];
    case (eff_size)
      2'b00: begin
        be    = 4'b1111;
        fault = (eff_addr[1:0] != 2'b00);
      end
      2'b01: begin
        be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        fault = eff_addr[0];
      end
      2'b10: begin
        be = 4'b0001 << eff_addr[1:0];
      end
      default: begin
        fault = 1'b1;
      end
    endcase
    if ((eff_addr < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH_WORDS)))
      fault = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (mem_if.require_mem_access) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= CW'(1)) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign commit = enter_done && !rst && eff_write && !fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                         <= IDLE;
      mem_if.data_mem_access_ready_n <= 1'b1;
      mem_if.data_from_mem          <= 32'h0;
      mem_if.access_err             <= 1'b0;
    end else begin
      state                         <= state_nxt;
      mem_if.data_mem_access_ready_n <= !enter_done;
      mem_if.access_err             <= enter_done && fault;
      if (enter_done) begin
        if (fault)
          mem_if.data_from_mem <= 32'h0;
        else if (!eff_write)
          mem_if.data_from_mem <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && mem_if.require_mem_access) begin
      req_write <= mem_if.write;
      req_size  <= mem_if.size;
      req_addr  <= mem_if.data_mem_addr;
      req_data  <= mem_if.data_to_mem;
      cnt       <= CW'(WAIT_CYCLES);
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Array has no reset so it maps onto block RAM and survives rst.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= eff_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: WAIT_CYCLES=2 instance driven from a vector table, plus a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  data_mem_if a_if ();
  data_mem_if b_if ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (a_if)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .mem_if (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge in an IDLE cycle; returns at the negedge of the DONE cycle.
  task automatic a_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble,
                          output int lat, output logic [31:0] rd, output logic err);
    a_if.require_mem_access = 1'b1;
    a_if.write              = wr;
    a_if.size               = sz;
    a_if.data_mem_addr      = addr;
    a_if.data_to_mem        = data;
    @(posedge clk);
    #1;
    if (scramble) begin
      a_if.data_mem_addr = addr ^ 32'h4;
      a_if.data_to_mem   = ~data;
      a_if.write         = ~wr;
      a_if.size          = 2'b11;
    end else begin
      a_if.require_mem_access = 1'b0;
    end
    lat = 0;
    rd  = 32'h0;
    err = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) a_if.require_mem_access = 1'b0;
      if (a_if.data_mem_access_ready_n === 1'b0) begin
        lat = k;
        rd  = a_if.data_from_mem;
        err = a_if.access_err;
        break;
      end
    end
  endtask

  task automatic a_read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    int          lat;
    logic [31:0] rd;
    logic        err;
    a_access(1'b0, 2'b00, addr, 32'h0, 1'b0, lat, rd, err);
    chk({name, "_lat"}, lat, 3);
    chk({name, "_err"}, {31'b0, err}, 32'h0);
    chk({name, "_data"}, rd, exp);
    @(negedge clk);
  endtask

  task automatic b_access(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err);
    b_if.require_mem_access = 1'b1;
    b_if.write              = wr;
    b_if.size               = 2'b00;
    b_if.data_mem_addr      = addr;
    b_if.data_to_mem        = data;
    @(posedge clk);
    #1;
    b_if.require_mem_access = 1'b0;
    @(negedge clk);
    chk({name, "_ready_c1"}, {31'b0, b_if.data_mem_access_ready_n}, 32'h0);
    chk({name, "_err"}, {31'b0, b_if.access_err}, {31'b0, exp_err});
    chk({name, "_data"}, b_if.data_from_mem, exp_data);
    @(negedge clk);
    chk({name, "_ready_c2"}, {31'b0, b_if.data_mem_access_ready_n}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    logic [31:0] prev_data;
    logic [31:0] exp_data;
    logic        seen_low;

    tests = 0;
    fails = 0;

    //           wr    sz     addr           data           exp_rd         err
    vecs[0]  = {1'b1, 2'b00, 32'h0000_0000, 32'h1357_9BDF, 32'h0,         1'b0};
    vecs[1]  = {1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = {1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = {1'b1, 2'b10, 32'h0000_0012, 32'h5A5A_5A5A, 32'h0,         1'b0};
    vecs[4]  = {1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF, 1'b0};
    vecs[5]  = {1'b1, 2'b01, 32'h0000_0010, 32'h1234_1234, 32'h0,         1'b0};
    vecs[6]  = {1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE5A_1234, 1'b0};
    vecs[7]  = {1'b0, 2'b10, 32'h0000_0013, 32'h0,         32'hDE5A_1234, 1'b0};
    vecs[8]  = {1'b0, 2'b00, 32'h0000_0011, 32'h0,         32'h0,         1'b1};
    vecs[9]  = {1'b1, 2'b00, 32'h0000_1000, 32'h0BAD_F00D, 32'h0,         1'b1};
    vecs[10] = {1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 1'b0};
    vecs[11] = {1'b1, 2'b01, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[12] = {1'b0, 2'b11, 32'h0000_0010, 32'h0,         32'h0,         1'b1};
    vecs[13] = {1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE5A_1234, 1'b0};
    vecs[14] = {1'b1, 2'b00, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[15] = {1'b0, 2'b01, 32'h0000_0022, 32'h0,         32'hCAFE_F00D, 1'b0};

    rst = 1'b1;
    a_if.require_mem_access = 1'b0;
    a_if.write = 1'b0;
    a_if.size = 2'b00;
    a_if.data_mem_addr = 32'h0;
    a_if.data_to_mem = 32'h0;
    b_if.require_mem_access = 1'b0;
    b_if.write = 1'b0;
    b_if.size = 2'b00;
    b_if.data_mem_addr = 32'h0;
    b_if.data_to_mem = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_ready_n", {31'b0, a_if.data_mem_access_ready_n}, 32'h1);
      chk("reset_data",    a_if.data_from_mem, 32'h0);
      chk("reset_err",     {31'b0, a_if.access_err}, 32'h0);
      chk("reset0_ready_n", {31'b0, b_if.data_mem_access_ready_n}, 32'h1);
    end

    prev_data = 32'h0;
    for (int i = 0; i < 16; i++) begin
      a_access(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].data, 1'b0, lat, rd, err);
      if (vecs[i].exp_err)  exp_data = 32'h0;
      else if (vecs[i].wr)  exp_data = prev_data;
      else                  exp_data = vecs[i].exp_rd;
      prev_data = exp_data;
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_data", i), rd, exp_data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after", i), {31'b0, a_if.data_mem_access_ready_n}, 32'h1);
      chk($sformatf("vec%0d_err_after", i), {31'b0, a_if.access_err}, 32'h0);
    end

    // Inputs scrambled during BUSY: the latched write to 0x24 must land, 0x20 untouched.
    a_access(1'b1, 2'b00, 32'h0000_0024, 32'h7777_7777, 1'b1, lat, rd, err);
    chk("stable_latency", lat, 3);
    chk("stable_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    a_read_check("stable_rd24", 32'h0000_0024, 32'h7777_7777);
    a_read_check("stable_rd20", 32'h0000_0020, 32'hCAFE_F00D);

    // Reset in BUSY aborts the write of 0x11111111 to 0x20.
    a_if.require_mem_access = 1'b1;
    a_if.write              = 1'b1;
    a_if.size               = 2'b00;
    a_if.data_mem_addr      = 32'h0000_0020;
    a_if.data_to_mem        = 32'h1111_1111;
    @(posedge clk);
    #1;
    a_if.require_mem_access = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen_low = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst = 1'b0;
      if (a_if.data_mem_access_ready_n !== 1'b1) seen_low = 1'b1;
    end
    chk("rst_abort_no_ready", {31'b0, seen_low}, 32'h0);
    chk("rst_abort_data", a_if.data_from_mem, 32'h0);
    a_read_check("rst_abort_rd20", 32'h0000_0020, 32'hCAFE_F00D);

    // Zero wait states: completion in cycle 1.
    b_access("w0_write", 1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 32'h0, 1'b0);
    b_access("w0_read",  1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 1'b0);
    b_access("w0_fault", 1'b0, 32'h0000_0041, 32'h0, 32'h0, 1'b1);
    b_access("w0_oob",   1'b1, 32'h0000_1040, 32'hFFFF_FFFF, 32'h0, 1'b1);
    b_access("w0_reread", 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
